// File: rtl/matrix_mem_responder_if.sv
// Controller bus plus host load/dump streams for matrix_mem_responder.
// The master side is the controller/host; the slave side is the responder.
interface matrix_mem_responder_if #(
    parameter int DW = 8,
    parameter int IW = 4
);
    logic [1:0]    matrix_select;
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          ctrl_busy;
    logic          load_start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          load_done;
    logic          dump_start;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          dump_done;
    logic          busy;

    modport master (
        output matrix_select, row, col, write_enable, write_data,
        output ctrl_busy, load_start, in_valid, in_data,
        output dump_start, out_ready,
        input  read_data, in_ready, load_done,
        input  out_valid, out_data, dump_done, busy
    );

    modport slave (
        input  matrix_select, row, col, write_enable, write_data,
        input  ctrl_busy, load_start, in_valid, in_data,
        input  dump_start, out_ready,
        output read_data, in_ready, load_done,
        output out_valid, out_data, dump_done, busy
    );
endinterface

// File: rtl/matrix_mem_responder.sv
// Three N x N banks (A, B, C) behind a controller port, with a host-side
// streaming FSM that loads A then B and dumps C, both row-major.
module matrix_mem_responder #(
    parameter int N  = 10,
    parameter int DW = 8,
    parameter int IW = 4
) (
    input logic clk,
    input logic reset,
    matrix_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DUMP,
        FIN
    } state_t;

    localparam logic [IW-1:0] NL  = IW'(N);
    localparam logic [IW-1:0] NM1 = IW'(N - 1);

    logic [DW-1:0] mem [3][N][N];

    state_t        state;
    state_t        state_n;
    logic          sel;
    logic          sel_n;
    logic [IW-1:0] r;
    logic [IW-1:0] r_n;
    logic [IW-1:0] c;
    logic [IW-1:0] c_n;
    logic          ov;
    logic          ov_n;
    logic [DW-1:0] od;
    logic [DW-1:0] od_n;
    logic          ld;
    logic          ld_n;
    logic          dd;
    logic          dd_n;
    logic          load_we;

    logic          last_c;
    logic          last_r;
    logic [IW-1:0] r_adv;
    logic [IW-1:0] c_adv;
    logic          in_rng;
    logic          ctrl_we;
    logic [DW-1:0] rd;

    assign last_c = (c == NM1);
    assign last_r = (r == NM1);
    assign c_adv  = last_c ? '0 : c + 1'b1;
    assign r_adv  = last_c ? (last_r ? '0 : r + 1'b1) : r;

    assign in_rng  = (bus.row < NL) && (bus.col < NL);
    assign ctrl_we = bus.write_enable && (bus.matrix_select == 2'd2) && in_rng;

    always_comb begin
        rd = '0;
        if (in_rng) begin
            unique case (bus.matrix_select)
                2'd0:    rd = mem[0][bus.row][bus.col];
                2'd1:    rd = mem[1][bus.row][bus.col];
                2'd2:    rd = mem[2][bus.row][bus.col];
                default: rd = '0;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        r_n     = r;
        c_n     = c;
        ov_n    = ov;
        od_n    = od;
        ld_n    = 1'b0;
        dd_n    = 1'b0;
        load_we = 1'b0;
        unique case (state)
            IDLE: begin
                // Load takes priority; a blocked load is dropped, not queued.
                if (bus.load_start && !bus.ctrl_busy) begin
                    state_n = LOAD;
                    sel_n   = 1'b0;
                    r_n     = '0;
                    c_n     = '0;
                end else if (bus.dump_start) begin
                    state_n = DUMP;
                    r_n     = '0;
                    c_n     = '0;
                    od_n    = mem[2][0][0];
                    ov_n    = 1'b1;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    load_we = 1'b1;
                    r_n     = r_adv;
                    c_n     = c_adv;
                    if (last_c && last_r) begin
                        if (sel) begin
                            state_n = FIN;
                            ld_n    = 1'b1;
                        end else begin
                            sel_n = 1'b1;
                        end
                    end
                end
            end
            DUMP: begin
                if (bus.out_ready) begin
                    if (last_c && last_r) begin
                        state_n = FIN;
                        ov_n    = 1'b0;
                        dd_n    = 1'b1;
                    end else begin
                        r_n  = r_adv;
                        c_n  = c_adv;
                        od_n = mem[2][r_adv][c_adv];
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 1'b0;
            r     <= '0;
            c     <= '0;
            ov    <= 1'b0;
            od    <= '0;
            ld    <= 1'b0;
            dd    <= 1'b0;
        end else begin
            state <= state_n;
            sel   <= sel_n;
            r     <= r_n;
            c     <= c_n;
            ov    <= ov_n;
            od    <= od_n;
            ld    <= ld_n;
            dd    <= dd_n;
        end
    end

    // Host writes only A/B and the controller only C, so they never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        mem[b][i][j] <= '0;
                    end
                end
            end
        end else begin
            if (load_we) begin
                if (sel) begin
                    mem[1][r][c] <= bus.in_data;
                end else begin
                    mem[0][r][c] <= bus.in_data;
                end
            end
            if (ctrl_we) begin
                mem[2][bus.row][bus.col] <= bus.write_data;
            end
        end
    end

    assign bus.read_data = rd;
    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = ov;
    assign bus.out_data  = od;
    assign bus.load_done = ld;
    assign bus.dump_done = dd;
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Directed bench for matrix_mem_responder: reset, load, controller
// access, dump with stall, start arbitration and mid-load reset.
module tb_matrix_mem_responder;
    localparam int N  = 10;
    localparam int DW = 8;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    matrix_mem_responder_if #(.DW(DW), .IW(IW)) bus ();

    matrix_mem_responder #(
        .N (N),
        .DW(DW),
        .IW(IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] s, input int rr, input int cc);
        bus.write_enable  = 1'b0;
        bus.matrix_select = s;
        bus.row           = rr[IW-1:0];
        bus.col           = cc[IW-1:0];
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input int rr, input int cc,
                      input logic [DW-1:0] d);
        bus.matrix_select = s;
        bus.row           = rr[IW-1:0];
        bus.col           = cc[IW-1:0];
        bus.write_data    = d;
        bus.write_enable  = 1'b1;
        tick;
        bus.write_enable  = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int bad;
        int stall_bad;
        logic [DW-1:0] v;

        bus.matrix_select = '0;
        bus.row           = '0;
        bus.col           = '0;
        bus.write_enable  = 1'b0;
        bus.write_data    = '0;
        bus.ctrl_busy     = 1'b0;
        bus.load_start    = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.dump_start    = 1'b0;
        bus.out_ready     = 1'b0;

        repeat (3) tick;
        @(negedge clk) reset = 1'b0;
        tick;

        rd(2'd0, 0, 0); check("rst_a00", bus.read_data, 0);
        rd(2'd1, 0, 0); check("rst_b00", bus.read_data, 0);
        rd(2'd2, 0, 0); check("rst_c00", bus.read_data, 0);
        rd(2'd0, 9, 9); check("rst_a99", bus.read_data, 0);
        rd(2'd1, 9, 9); check("rst_b99", bus.read_data, 0);
        rd(2'd2, 9, 9); check("rst_c99", bus.read_data, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_load_done", bus.load_done, 0);
        check("rst_dump_done", bus.dump_done, 0);
        check("rst_busy", bus.busy, 0);

        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        check("load_in_ready", bus.in_ready, 1);
        check("load_busy", bus.busy, 1);

        done_cnt = 0;
        for (int k = 0; k < 2 * N * N; k++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'hEE;
            tick;
            done_cnt += int'(bus.load_done);
            bus.in_valid = 1'b1;
            bus.in_data  = k[7:0];
            tick;
            done_cnt += int'(bus.load_done);
        end
        bus.in_valid = 1'b0;
        check("load_done_after_last", bus.load_done, 1);
        check("load_fin_in_ready", bus.in_ready, 0);
        tick;
        check("load_done_cleared", bus.load_done, 0);
        check("load_idle_busy", bus.busy, 0);
        check("load_done_count", done_cnt, 1);

        rd(2'd0, 3, 4); check("a34", bus.read_data, 34);
        rd(2'd0, 9, 9); check("a99", bus.read_data, 99);
        rd(2'd1, 0, 0); check("b00", bus.read_data, 100);
        rd(2'd1, 9, 9); check("b99", bus.read_data, 199);

        wr(2'd2, 5, 7, 8'hA5);
        rd(2'd2, 5, 7); check("c57_write", bus.read_data, 8'hA5);
        wr(2'd0, 3, 4, 8'hFF);
        rd(2'd0, 3, 4); check("a34_protected", bus.read_data, 34);
        wr(2'd1, 0, 0, 8'hFF);
        rd(2'd1, 0, 0); check("b00_protected", bus.read_data, 100);
        wr(2'd2, 10, 0, 8'h77);
        rd(2'd2, 10, 0); check("c_row10_zero", bus.read_data, 0);
        rd(2'd2, 0, 0); check("c00_untouched", bus.read_data, 0);
        rd(2'd3, 5, 7); check("sel3_zero", bus.read_data, 0);

        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                v = 8'(i * 10 + j);
                wr(2'd2, i, j, v);
            end
        end
        rd(2'd2, 4, 2); check("c42_preload", bus.read_data, 42);

        bus.dump_start = 1'b1;
        tick;
        bus.dump_start = 1'b0;
        bus.out_ready  = 1'b1;
        check("dump1_busy", bus.busy, 1);
        bad = 0;
        for (int i = 0; i < N * N; i++) begin
            if (!(bus.out_valid === 1'b1 && bus.out_data === i[7:0])) bad++;
            if (bus.dump_done !== 1'b0) bad++;
            tick;
        end
        check("dump1_beats_bad", bad, 0);
        check("dump1_done", bus.dump_done, 1);
        check("dump1_valid_low", bus.out_valid, 0);
        tick;
        check("dump1_done_cleared", bus.dump_done, 0);
        check("dump1_idle", bus.busy, 0);

        bus.dump_start = 1'b1;
        tick;
        bus.dump_start = 1'b0;
        bad = 0;
        stall_bad = 0;
        for (int i = 0; i < N * N; i++) begin
            if (!(bus.out_valid === 1'b1 && bus.out_data === i[7:0])) bad++;
            if (i == 50) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    tick;
                    if (!(bus.out_valid === 1'b1 && bus.out_data === 8'd50))
                        stall_bad++;
                end
                bus.out_ready = 1'b1;
            end
            if (i == 10) begin
                bus.matrix_select = 2'd2;
                bus.row           = 4'd1;
                bus.col           = 4'd1;
                bus.write_data    = 8'hCC;
                bus.write_enable  = 1'b1;
            end
            tick;
            bus.write_enable = 1'b0;
        end
        check("dump2_beats_bad", bad, 0);
        check("dump2_stall_bad", stall_bad, 0);
        check("dump2_done", bus.dump_done, 1);
        rd(2'd2, 1, 1); check("c11_written", bus.read_data, 8'hCC);
        tick;
        check("dump2_idle", bus.busy, 0);

        bus.ctrl_busy  = 1'b1;
        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        check("blocked_busy", bus.busy, 0);
        check("blocked_in_ready", bus.in_ready, 0);
        tick;
        check("blocked_not_queued", bus.busy, 0);
        bus.ctrl_busy = 1'b0;
        tick;
        check("blocked_still_idle", bus.in_ready, 0);

        bus.load_start = 1'b1;
        bus.dump_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        bus.dump_start = 1'b0;
        check("both_in_ready", bus.in_ready, 1);
        check("both_no_dump", bus.out_valid, 0);

        for (int k = 0; k < 57; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(k + 1);
            tick;
        end
        bus.in_valid = 1'b0;
        rd(2'd0, 0, 5); check("partial_a05", bus.read_data, 6);
        rd(2'd0, 5, 6); check("partial_a56", bus.read_data, 57);

        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", bus.in_ready, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_load_done", bus.load_done, 0);
        check("mid_rst_dump_done", bus.dump_done, 0);
        rd(2'd0, 0, 5); check("mid_rst_a05", bus.read_data, 0);
        rd(2'd2, 1, 1); check("mid_rst_c11", bus.read_data, 0);
        @(negedge clk) reset = 1'b0;
        tick;

        bus.load_start = 1'b1;
        tick;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h5A;
        tick;
        bus.in_valid   = 1'b0;
        rd(2'd0, 0, 0); check("restart_a00", bus.read_data, 8'h5A);
        rd(2'd0, 0, 1); check("restart_a01", bus.read_data, 0);
        check("restart_in_ready", bus.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_mem_responder.md
Name: matrix_mem_responder

Overview:
- Memory-side responder for the matrix multiply controller.
- Holds three N x N banks of DW-bit words: A (select 0), B (select 1) and result C (select 2).
- Serves the controller's row/col/matrix_select read and write port.
- A host-side streaming FSM loads A and B with a valid/ready stream and dumps C out with a valid/ready stream.

Parameters:
N, 10, matrix dimension (rows = cols = N); legal range 2..15
DW, 8, data word width
IW, 4, row/col index width; must satisfy 2^IW > N

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
matrix_select  input  2  controller bank select: 0=A, 1=B, 2=C, 3=unused
row  input  IW  controller row index
col  input  IW  controller column index
write_enable  input  1  controller write strobe
write_data  input  DW  controller write data
read_data  output  DW  controller read data
ctrl_busy  input  1  high while the multiply controller is running; blocks host load
load_start  input  1  one-cycle request to begin loading A then B
in_valid  input  1  host load beat valid
in_data  input  DW  host load data, row-major
in_ready  output  1  responder accepts a load beat
load_done  output  1  one-cycle pulse after the final load beat
dump_start  input  1  one-cycle request to stream C out
out_valid  output  1  dump beat valid
out_data  output  DW  dump data, row-major
out_ready  input  1  host accepts a dump beat
dump_done  output  1  one-cycle pulse after the final dump handshake
busy  output  1  high while the host FSM is not in IDLE

Behaviour:
- Reset (async, active-high): all banks cleared to 0; FSM to IDLE; in_ready=0, out_valid=0, out_data=0, load_done=0, dump_done=0, busy=0. read_data is combinational and therefore reads 0 after reset.
- Controller read path:
  - read_data is combinational from the current matrix_select/row/col, with zero added latency.
  - The controller registers its address in one cycle and samples read_data in the following cycle.
  - Returns 0 if matrix_select==3 or row>=N or col>=N.
- Controller write path:
  - On a posedge with write_enable=1, matrix_select==2, row<N and col<N: C[row][col] <= write_data.
  - All other writes are silently dropped, so the controller can never corrupt A or B.
  - Controller writes are honoured in every host FSM state.
- Host FSM states: IDLE, LOAD, DUMP, FIN.
- IDLE:
  - load_start=1 and ctrl_busy=0: go to LOAD; counters sel=0, r=0, c=0.
  - else dump_start=1: go to DUMP; r=0, c=0; out_data <= C[0][0]; out_valid <= 1.
  - If load_start and dump_start are high together, load wins.
  - load_start while ctrl_busy=1 is ignored; it is not queued.
- LOAD:
  - in_ready=1 (combinational from state).
  - Each cycle with in_valid=1: bank[sel][r][c] <= in_data, then advance c; on c==N-1, c<=0 and r++; on r==N-1 and c==N-1, r<=0 and sel: 0 to 1.
  - The beat at sel=1, r=N-1, c=N-1 (beat 2*N*N, i.e. 200 at defaults) goes to FIN with load_done=1 for one cycle.
  - in_valid=0 stalls; counters hold.
- DUMP:
  - out_valid stays 1 and out_data stays stable until out_ready=1.
  - On a handshake, advance r/c and load out_data <= C[next]; out_valid remains 1, giving one beat per cycle under continuous ready.
  - The handshake on the last element (N*N-th beat) sets out_valid<=0 and goes to FIN with dump_done=1 for one cycle.
  - Same-cycle controller write to the cell being fetched: out_data takes the pre-write (old) value.
- FIN: one cycle, then back to IDLE. load_start and dump_start are ignored outside IDLE.
- Mid-operation reset: immediate abort to the reset state; partially loaded banks are cleared.
- busy=1 in LOAD, DUMP and FIN.

Test Plan:
- Reset, then read select 0/1/2 at (0,0) and (9,9) -> read_data=0; all host outputs 0.
- load_start, then 200 beats of in_data=k mod 256 (k=0..199) with in_valid toggling every other cycle -> load_done pulses exactly once, one cycle after beat 199. Reads then return A[3][4]=34, B[0][0]=100, B[9][9]=199.
- Controller write select=2, row=5, col=7, data=0xA5, then read -> 0xA5. Writes with select=0 and with row=10 -> A is unchanged and nothing is written.
- dump_start with C preloaded to C[r][c]=r*10+c, out_ready held high -> 100 consecutive beats 0..99, dump_done one cycle after the last beat. Repeat with out_ready low for 3 cycles at beat 50 -> out_data holds 50 stable.
- load_start while ctrl_busy=1 -> stays IDLE, in_ready=0. load_start and dump_start together -> LOAD entered.
- Assert reset after 57 load beats -> all outputs 0 and A[0][5]=0. A fresh load_start then restarts at A[0][0].
